// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 serial receiver.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned DEF_CLK_FREQ = 50000000;
    localparam int unsigned DEF_BAUD     = 115200;

    // Clocks per line bit; integer division, truncating.
    function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchroniser for the asynchronous serial line plus falling-edge detect.
// All stages reset to 1 so an idle line never looks like a start edge.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;

    // Shift the raw line through the flop chain; remember last synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '1;
            prev       <= 1'b1;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], din};
            prev       <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign dout = sync_chain[SYNC_STAGES-1];
    // High in the first cycle the synchronised line reads low after reading high.
    assign fall = prev & ~dout;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: centre-samples each bit with its own clock-count
// divider and presents each good byte with a one-cycle valid strobe.
// CLKS_PER_BIT must be at least 8 and SYNC_STAGES at least 2.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
    parameter int unsigned BAUD         = DEF_BAUD,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       RST_clk,
    input  logic       RST_n,
    input  logic       uart_rx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic                 rx_s;
    logic                 rx_fall;
    rx_state_t            state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (RST_clk),
        .rst_n(RST_n),
        .din  (uart_rx_data),
        .dout (rx_s),
        .fall (rx_fall)
    );

    // Frame FSM with counters, shift register and registered outputs.
    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    rx_busy <= 1'b0;
                    if (rx_fall) begin
                        state   <= START;
                        clk_cnt <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_HALF) begin
                        if (!rx_s) begin
                            clk_cnt <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            // Line went back high before mid start bit: a glitch.
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            // Leave at mid stop bit so the next start edge is caught.
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            rx_busy  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    // Break or stuck-low line: ignore everything until it idles high.
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
